plic_target: RTL

//  Receiving end of the PLIC gateway protocol: collects the held request lines from SRC_NUM gateways.

---
 rtl/plic_target_if.sv | 10 +
 rtl/plic_target.sv | 79 +++++++
 2 files changed

// File: rtl/plic_target_if.sv
// plic_target_if: claim/complete register bus between the hart side and the PLIC target.
interface plic_target_if;
  logic        cfg_we;
  logic        cfg_re;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  modport master (output cfg_we, cfg_re, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave (input cfg_we, cfg_re, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/plic_target.sv
// plic_target: priority arbitration, irq generation and claim/complete handling for SRC_NUM gateways.
module plic_target #(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_NUM-1:0] req_i,
  output logic [SRC_NUM-1:0] req_complete_o,
  output logic               irq_o,
  plic_target_if.slave       cfg
);
  localparam int ID_W = 5;
  logic [PRIO_W-1:0]  prio_q [SRC_NUM:1];
  logic [PRIO_W-1:0]  prio_d [SRC_NUM:1];
  logic [SRC_NUM:1]   enable_q, enable_d, in_service_q, in_service_d;
  logic [PRIO_W-1:0]  thr_q, thr_d, best_prio, rd_prio;
  logic [SRC_NUM-1:0] complete_q, complete_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    best_id, cid;
  logic [5:0]         prio_idx;
  logic               prio_sel, claim, is_complete;
  assign prio_idx    = cfg.cfg_addr[7:2];
  assign prio_sel    = cfg.cfg_addr[1:0] == 2'b00 && prio_idx != 6'd0 && prio_idx <= 6'(SRC_NUM);
  assign claim       = cfg.cfg_re && cfg.cfg_addr == 8'h88;
  assign is_complete = cfg.cfg_we && cfg.cfg_addr == 8'h88;
  assign cid         = cfg.cfg_wdata[ID_W-1:0];
  // Strict '>' keeps the lowest ID on ties and rejects priority 0.
  always_comb begin
    best_id = '0;
    best_prio = '0;
    for (int k = 1; k <= SRC_NUM; k++)
      if (req_i[k-1] && !in_service_q[k] && enable_q[k] && prio_q[k] > best_prio) begin
        best_id = ID_W'(k);
        best_prio = prio_q[k];
      end
  end
  always_comb begin
    prio_d = prio_q;
    rd_prio = '0;
    enable_d = (cfg.cfg_we && cfg.cfg_addr == 8'h80) ? cfg.cfg_wdata[SRC_NUM:1] : enable_q;
    thr_d = (cfg.cfg_we && cfg.cfg_addr == 8'h84) ? cfg.cfg_wdata[PRIO_W-1:0] : thr_q;
    for (int k = 1; k <= SRC_NUM; k++) begin
      prio_d[k] = (cfg.cfg_we && prio_sel && prio_idx == 6'(k)) ? cfg.cfg_wdata[PRIO_W-1:0] : prio_q[k];
      rd_prio = (prio_idx == 6'(k)) ? prio_q[k] : rd_prio;
      // A live pulse blocks a second completion before in_service clears.
      complete_d[k-1] = is_complete && cid == ID_W'(k) && in_service_q[k] && !complete_q[k-1];
      in_service_d[k] = (in_service_q[k] && !complete_q[k-1]) || (claim && best_id == ID_W'(k));
    end
    rdata_d = !cfg.cfg_re ? rdata_q :
              cfg.cfg_addr == 8'h88 ? 32'(best_id) :
              cfg.cfg_addr == 8'h80 ? 32'({enable_q, 1'b0}) :
              cfg.cfg_addr == 8'h84 ? 32'(thr_q) :
              prio_sel ? 32'(rd_prio) : 32'd0;
    irq_d = best_id != '0 && best_prio > thr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio_q <= '{default: '0};
      enable_q <= '0;
      in_service_q <= '0;
      thr_q <= '0;
      complete_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      enable_q <= enable_d;
      in_service_q <= in_service_d;
      thr_q <= thr_d;
      complete_q <= complete_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
  assign req_complete_o = complete_q;
  assign irq_o = irq_q;
  assign cfg.cfg_rdata = rdata_q;
endmodule
